// File: rtl/shl_iter_unit.sv
// Iterative left shifter/rotator: resolves one power-of-two stage (16,8,4,2,1) per clock.
// Latency: result valid SHW cycles after the accept edge; throughput one op per SHW+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE; kill aborts anything.
module shl_iter_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_rot,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Stage counter only needs to address the SHW bits of the shift amount.
    localparam int CW = (SHW > 1) ? $clog2(SHW) : 1;
    // Width kept one bit wider than SHW so WIDTH itself is representable.
    localparam logic [SHW:0] WIDTH_L = (SHW+1)'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   amt;
    logic             rot;
    logic [CW-1:0]    cnt;

    logic [SHW:0]     stage_sh;
    logic [WIDTH-1:0] stage_res;

    // One shift stage of distance 2^cnt; rotate ORs back the bits pushed out the top.
    always_comb begin
        stage_sh  = (SHW+1)'(1) << cnt;
        stage_res = acc << stage_sh;
        if (rot) begin
            stage_res = stage_res | (acc >> (WIDTH_L - stage_sh));
        end
    end

    assign in_ready  = (state == IDLE) && !kill;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = acc;

    // Control FSM and datapath: reset beats kill, kill beats every handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            amt   <= '0;
            rot   <= 1'b0;
            cnt   <= '0;
        end else if (kill) begin
            // acc/amt deliberately keep their contents; only control unwinds.
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= in_data;
                        amt   <= in_shamt;
                        rot   <= in_rot;
                        cnt   <= CW'(SHW - 1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Every stage is visited even when its bit is clear, so latency is fixed.
                    if (amt[cnt]) begin
                        acc <= stage_res;
                    end
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
